// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, fetches one instruction at a time over a
// valid/ready handshake, offers it to decode and picks the next PC on writeback.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,

    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,

    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,

    input  logic        wb_valid,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        mpc_wr,
    input  logic [31:0] mret_pc,

    output logic        misalign_err,
    output logic [31:0] fetch_cnt
);

    localparam logic [31:0] EBREAK = 32'h0010_0073;

    typedef enum logic [1:0] {
        REQ      = 2'd0,
        WAIT_RSP = 2'd1,
        ISSUE    = 2'd2,
        EXEC     = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] inst_q;
    logic [31:0] inst_pc_q;
    logic [31:0] fetch_cnt_q;
    logic        misalign_q;
    logic [31:0] next_pc;

    always_comb begin
        state_next = state;
        case (state)
            REQ:      if (imem_req_ready) state_next = WAIT_RSP;
            WAIT_RSP: if (imem_rsp_valid) state_next = ISSUE;
            ISSUE:    if (inst_ready)     state_next = EXEC;
            EXEC:     if (wb_valid)       state_next = REQ;
            default:  state_next = REQ;
        endcase
    end

    // CSR trap/return target outranks a branch/jump redirect.
    always_comb begin
        next_pc = pc + 32'd4;
        if (mpc_wr) begin
            next_pc = mret_pc;
        end else if (redirect_valid) begin
            next_pc = redirect_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= REQ;
            pc          <= RESET_PC;
            inst_q      <= 32'd0;
            inst_pc_q   <= 32'd0;
            fetch_cnt_q <= 32'd0;
            misalign_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == WAIT_RSP && imem_rsp_valid) begin
                inst_q    <= imem_rsp_err ? EBREAK : imem_rsp_data;
                inst_pc_q <= pc;
            end
            if (state == ISSUE && inst_ready) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            // A misaligned target is flagged and then forced onto a word boundary.
            if (state == EXEC && wb_valid) begin
                pc <= {next_pc[31:2], 2'b00};
                if (next_pc[1:0] != 2'b00) begin
                    misalign_q <= 1'b1;
                end
            end
        end
    end

    assign imem_req_valid = !rst && (state == REQ);
    assign imem_addr      = imem_req_valid ? pc : 32'd0;
    assign inst_valid     = !rst && (state == ISSUE);
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_cnt      = fetch_cnt_q;
    assign misalign_err   = misalign_q;

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed scenarios plus randomized traffic
// checked against a PC/counter reference model.
module tb_ifu;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;
    localparam int          BOUND    = 50;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        wb_valid;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mpc_wr;
    logic [31:0] mret_pc;
    logic        misalign_err;
    logic [31:0] fetch_cnt;

    ifu #(.RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .wb_valid       (wb_valid),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mpc_wr         (mpc_wr),
        .mret_pc        (mret_pc),
        .misalign_err   (misalign_err),
        .fetch_cnt      (fetch_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: architectural PC, accept count, sticky misalign flag.
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic        m_mis;

    logic [31:0] o_addr, o_inst, o_inst_pc, o_next_addr;
    int          o_cycles;
    bit          o_timeout, o_stable;
    bit          noise = 1'b0;

    function automatic logic [31:0] spec_target(logic [31:0] pc, logic mpc, logic [31:0] mt,
                                                 logic rv, logic [31:0] rt);
        if (mpc) return mt;
        if (rv) return rt;
        return pc + 32'd4;
    endfunction

    task automatic model_retire(input logic mpc, input logic [31:0] mt,
                                input logic rv, input logic [31:0] rt);
        logic [31:0] t;
        t = spec_target(m_pc, mpc, mt, rv, rt);
        if (t % 4 != 0) m_mis = 1'b1;
        m_pc  = t - (t % 4);
        m_cnt = m_cnt + 32'd1;
    endtask

    task automatic clear_inputs();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'd0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b0;
        wb_valid       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        mpc_wr         = 1'b0;
        mret_pc        = 32'd0;
    endtask

    // Garbage on inputs the current phase must ignore; phase 0..3 = REQ..EXEC.
    task automatic drive_noise(input int phase);
        clear_inputs();
        if (noise) begin
            imem_rsp_valid = (phase != 1) && ($urandom_range(0, 1) == 1);
            imem_rsp_data  = $urandom;
            imem_rsp_err   = ($urandom_range(0, 1) == 1);
            inst_ready     = (phase != 2) && ($urandom_range(0, 1) == 1);
            wb_valid       = (phase != 3) && ($urandom_range(0, 1) == 1);
            redirect_valid = ($urandom_range(0, 1) == 1);
            redirect_pc    = $urandom;
            mpc_wr         = ($urandom_range(0, 1) == 1);
            mret_pc        = $urandom;
        end
    endtask

    // Drives one full instruction with the given stall counts and records observations.
    task automatic do_instr(input int rw, input int sw, input int dw, input int ww,
                            input logic [31:0] data, input logic err,
                            input logic mpc, input logic [31:0] mt,
                            input logic rv, input logic [31:0] rt);
        int k;
        o_cycles = 0; o_timeout = 1'b0; o_stable = 1'b1;
        k = 0;
        while (imem_req_valid !== 1'b1 && k < BOUND) begin @(negedge clk); k++; end
        if (k >= BOUND) o_timeout = 1'b1;
        o_addr = imem_addr;
        repeat (rw) begin drive_noise(0); @(negedge clk); o_cycles++; end
        clear_inputs(); imem_req_ready = 1'b1;
        @(negedge clk); o_cycles++;
        repeat (sw) begin drive_noise(1); @(negedge clk); o_cycles++; end
        clear_inputs(); imem_rsp_valid = 1'b1; imem_rsp_data = data; imem_rsp_err = err;
        @(negedge clk); o_cycles++;
        clear_inputs();
        k = 0;
        while (inst_valid !== 1'b1 && k < BOUND) begin @(negedge clk); o_cycles++; k++; end
        if (k >= BOUND) o_timeout = 1'b1;
        o_inst = inst; o_inst_pc = inst_pc;
        repeat (dw) begin
            drive_noise(2); @(negedge clk); o_cycles++;
            if (inst !== o_inst || inst_pc !== o_inst_pc || inst_valid !== 1'b1) o_stable = 1'b0;
        end
        clear_inputs(); inst_ready = 1'b1;
        @(negedge clk); o_cycles++;
        repeat (ww) begin drive_noise(3); @(negedge clk); o_cycles++; end
        clear_inputs(); wb_valid = 1'b1; mpc_wr = mpc; mret_pc = mt; redirect_valid = rv; redirect_pc = rt;
        @(negedge clk); o_cycles++;
        clear_inputs();
        k = 0;
        while (imem_req_valid !== 1'b1 && k < BOUND) begin @(negedge clk); o_cycles++; k++; end
        if (k >= BOUND) o_timeout = 1'b1;
        o_next_addr = imem_addr;
    endtask

    task automatic test_reset();
        clear_inputs(); rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (imem_req_valid !== 1'b0) $display("[TB] FAIL rst_req_valid: got %b expected 0", imem_req_valid); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("[TB] FAIL rst_inst_valid: got %b expected 0", inst_valid); else n_pass++;
        n_checks++; if (imem_addr !== 32'd0) $display("[TB] FAIL rst_addr: got %h expected 0", imem_addr); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_req_valid !== 1'b1) $display("[TB] FAIL post_rst_req_valid: got %b expected 1", imem_req_valid); else n_pass++;
        n_checks++; if (imem_addr !== RESET_PC) $display("[TB] FAIL post_rst_addr: got %h expected %h", imem_addr, RESET_PC); else n_pass++;
        n_checks++; if (inst !== 32'd0 || inst_pc !== 32'd0) $display("[TB] FAIL post_rst_inst: got %h/%h expected 0/0", inst, inst_pc); else n_pass++;
        n_checks++; if (fetch_cnt !== 32'd0) $display("[TB] FAIL post_rst_cnt: got %0d expected 0", fetch_cnt); else n_pass++;
        n_checks++; if (misalign_err !== 1'b0) $display("[TB] FAIL post_rst_mis: got %b expected 0", misalign_err); else n_pass++;
        n_checks++; if (inst_valid !== 1'b0) $display("[TB] FAIL post_rst_inst_valid: got %b expected 0", inst_valid); else n_pass++;
        m_pc = RESET_PC; m_cnt = 32'd0; m_mis = 1'b0;
    endtask

    task automatic test_sequential();
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            d = $urandom;
            do_instr(0, 0, 0, 0, d, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            n_checks++; if (o_addr !== RESET_PC + 32'(4 * i)) $display("[TB] FAIL seq_addr%0d: got %h expected %h", i, o_addr, RESET_PC + 32'(4 * i)); else n_pass++;
            n_checks++; if (o_inst !== d || o_inst_pc !== m_pc) $display("[TB] FAIL seq_inst%0d: got %h@%h expected %h@%h", i, o_inst, o_inst_pc, d, m_pc); else n_pass++;
            n_checks++; if (o_cycles != 4 || o_timeout) $display("[TB] FAIL seq_period%0d: got %0d (timeout %0d) expected 4", i, o_cycles, o_timeout); else n_pass++;
            model_retire(1'b0, 32'd0, 1'b0, 32'd0);
        end
        n_checks++; if (fetch_cnt !== 32'd3) $display("[TB] FAIL seq_cnt: got %0d expected 3", fetch_cnt); else n_pass++;
    endtask

    task automatic test_stalls();
        logic [31:0] d;
        d = $urandom;
        do_instr(2, 2, 2, 0, d, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        n_checks++; if (o_cycles != 10 || o_timeout) $display("[TB] FAIL stall_period: got %0d (timeout %0d) expected 10", o_cycles, o_timeout); else n_pass++;
        n_checks++; if (!o_stable) $display("[TB] FAIL stall_stable: got unstable expected stable inst %h", o_inst); else n_pass++;
        n_checks++; if (o_inst !== d || o_inst_pc !== m_pc) $display("[TB] FAIL stall_inst: got %h@%h expected %h@%h", o_inst, o_inst_pc, d, m_pc); else n_pass++;
        model_retire(1'b0, 32'd0, 1'b0, 32'd0);
        n_checks++; if (o_next_addr !== m_pc) $display("[TB] FAIL stall_next: got %h expected %h", o_next_addr, m_pc); else n_pass++;
    endtask

    task automatic test_priority();
        do_instr(0, 0, 0, 0, $urandom, 1'b0, 1'b1, 32'h8000_0100, 1'b1, 32'h8000_0200);
        model_retire(1'b1, 32'h8000_0100, 1'b1, 32'h8000_0200);
        n_checks++; if (o_next_addr !== 32'h8000_0100) $display("[TB] FAIL prio_mret: got %h expected 80000100", o_next_addr); else n_pass++;
        do_instr(0, 0, 0, 0, $urandom, 1'b0, 1'b0, 32'h8000_0100, 1'b1, 32'h8000_0200);
        model_retire(1'b0, 32'h8000_0100, 1'b1, 32'h8000_0200);
        n_checks++; if (o_next_addr !== 32'h8000_0200) $display("[TB] FAIL prio_redirect: got %h expected 80000200", o_next_addr); else n_pass++;
    endtask

    task automatic test_misalign();
        n_checks++; if (misalign_err !== 1'b0) $display("[TB] FAIL mis_before: got %b expected 0", misalign_err); else n_pass++;
        do_instr(0, 0, 0, 0, $urandom, 1'b0, 1'b0, 32'd0, 1'b1, 32'h8000_0102);
        model_retire(1'b0, 32'd0, 1'b1, 32'h8000_0102);
        n_checks++; if (o_next_addr !== 32'h8000_0100) $display("[TB] FAIL mis_addr: got %h expected 80000100", o_next_addr); else n_pass++;
        n_checks++; if (misalign_err !== 1'b1) $display("[TB] FAIL mis_set: got %b expected 1", misalign_err); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            do_instr(0, 1, 0, 1, $urandom, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
            model_retire(1'b0, 32'd0, 1'b0, 32'd0);
            n_checks++; if (misalign_err !== 1'b1) $display("[TB] FAIL mis_sticky%0d: got %b expected 1", i, misalign_err); else n_pass++;
        end
    endtask

    task automatic test_fault_wrap();
        do_instr(0, 0, 0, 0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
        n_checks++; if (o_inst !== EBREAK || o_inst_pc !== m_pc) $display("[TB] FAIL fault_inst: got %h@%h expected %h@%h", o_inst, o_inst_pc, EBREAK, m_pc); else n_pass++;
        model_retire(1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
        do_instr(0, 0, 0, 0, $urandom, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        n_checks++; if (o_addr !== 32'hFFFF_FFFC) $display("[TB] FAIL wrap_addr: got %h expected fffffffc", o_addr); else n_pass++;
        model_retire(1'b0, 32'd0, 1'b0, 32'd0);
        n_checks++; if (o_next_addr !== 32'h0000_0000) $display("[TB] FAIL wrap_next: got %h expected 00000000", o_next_addr); else n_pass++;
    endtask

    task automatic test_random();
        int rw, sw, dw, ww;
        logic [31:0] d, mt, rt;
        logic err, mpc, rv;
        noise = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rw = $urandom_range(0, 3); sw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3); ww = $urandom_range(0, 3);
            d = $urandom; err = ($urandom_range(0, 7) == 0);
            mpc = ($urandom_range(0, 3) == 0); rv = ($urandom_range(0, 2) == 0);
            mt = $urandom; rt = $urandom;
            if ($urandom_range(0, 1) == 1) begin mt[1:0] = 2'b00; rt[1:0] = 2'b00; end
            do_instr(rw, sw, dw, ww, d, err, mpc, mt, rv, rt);
            n_checks++; if (o_timeout) $display("[TB] FAIL rnd_timeout%0d: got timeout expected handshake", i); else n_pass++;
            n_checks++; if (o_addr !== m_pc) $display("[TB] FAIL rnd_addr%0d: got %h expected %h", i, o_addr, m_pc); else n_pass++;
            n_checks++; if (o_inst !== (err ? EBREAK : d) || o_inst_pc !== m_pc) $display("[TB] FAIL rnd_inst%0d: got %h@%h expected %h@%h", i, o_inst, o_inst_pc, err ? EBREAK : d, m_pc); else n_pass++;
            n_checks++; if (o_cycles != 4 + rw + sw + dw + ww) $display("[TB] FAIL rnd_period%0d: got %0d expected %0d", i, o_cycles, 4 + rw + sw + dw + ww); else n_pass++;
            n_checks++; if (!o_stable) $display("[TB] FAIL rnd_stable%0d: got unstable expected stable", i); else n_pass++;
            model_retire(mpc, mt, rv, rt);
            n_checks++; if (o_next_addr !== m_pc) $display("[TB] FAIL rnd_next%0d: got %h expected %h", i, o_next_addr, m_pc); else n_pass++;
            n_checks++; if (fetch_cnt !== m_cnt) $display("[TB] FAIL rnd_cnt%0d: got %0d expected %0d", i, fetch_cnt, m_cnt); else n_pass++;
            n_checks++; if (misalign_err !== m_mis) $display("[TB] FAIL rnd_mis%0d: got %b expected %b", i, misalign_err, m_mis); else n_pass++;
        end
        noise = 1'b0;
    endtask

    task automatic test_reset_mid();
        int k;
        logic [31:0] d;
        k = 0;
        while (imem_req_valid !== 1'b1 && k < BOUND) begin @(negedge clk); k++; end
        clear_inputs(); imem_req_ready = 1'b1;
        @(negedge clk);
        clear_inputs(); imem_rsp_valid = 1'b1; imem_rsp_data = $urandom;
        @(negedge clk);
        clear_inputs();
        n_checks++; if (inst_valid !== 1'b1) $display("[TB] FAIL mid_issue: got inst_valid %b expected 1", inst_valid); else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (inst_valid !== 1'b0 || imem_req_valid !== 1'b0) $display("[TB] FAIL mid_rst_valids: got %b/%b expected 0/0", inst_valid, imem_req_valid); else n_pass++;
        n_checks++; if (fetch_cnt !== 32'd0) $display("[TB] FAIL mid_rst_cnt: got %0d expected 0", fetch_cnt); else n_pass++;
        n_checks++; if (misalign_err !== 1'b0 || inst !== 32'd0) $display("[TB] FAIL mid_rst_regs: got mis %b inst %h expected 0/0", misalign_err, inst); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== RESET_PC) $display("[TB] FAIL mid_post_addr: got %b/%h expected 1/%h", imem_req_valid, imem_addr, RESET_PC); else n_pass++;
        m_pc = RESET_PC; m_cnt = 32'd0; m_mis = 1'b0;
        d = $urandom;
        do_instr(0, 0, 0, 0, d, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
        n_checks++; if (o_inst !== d || o_inst_pc !== RESET_PC) $display("[TB] FAIL mid_resume: got %h@%h expected %h@%h", o_inst, o_inst_pc, d, RESET_PC); else n_pass++;
        model_retire(1'b0, 32'd0, 1'b0, 32'd0);
        n_checks++; if (fetch_cnt !== m_cnt || o_next_addr !== m_pc) $display("[TB] FAIL mid_resume_next: got %0d/%h expected %0d/%h", fetch_cnt, o_next_addr, m_cnt, m_pc); else n_pass++;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_sequential();
        test_stalls();
        test_priority();
        test_misalign();
        test_fault_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
